ex_logic_shift_unit: RTL
========================

EX_LOGIC_SHIFT_UNIT -- requirements
Module: ex_logic_shift_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 SHALL have parameter SHIFT_STEP, default 4, maximum shift bits per cycle; 1..DATA_WIDTH.
REQ-003 SHALL have derived width SHAMT_W = log2(DATA_WIDTH).
REQ-004 SHALL have ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  operation request.
- flush  input  1  abort the in-flight operation.
- funct  input  6  operation code, MIPS funct encoding.
- shamt  input  SHAMT_W  immediate shift amount.
- operand_1  input  DATA_WIDTH  rs value, or variable shift amount.
- operand_2  input  DATA_WIDTH  rt value.
- busy  output  1  multi-cycle operation in flight.
- done  output  1  one-cycle completion strobe.
- result  output  DATA_WIDTH  registered result.

Function
REQ-005 SHALL use states IDLE, SHIFT and DONE; a start is accepted only in IDLE or DONE, with flush low.
REQ-006 SHALL sample funct, shamt and operands at the accepting edge only.
REQ-007 SHALL implement these ops (funct value -> result):
- AND 100100: op1&op2. OR 100101 and JALR 001001: op1|op2. XOR 100110: op1^op2. NOR 100111: ~(op1|op2).
- SLT 101010: signed op1<op2, zero-extended 1/0. SLTU 101011: unsigned compare.
- SLL 000000 / SRL 000010 / SRA 000011: op2 shifted by shamt.
- SLLV 000100 / SRLV 000110 / SRAV 000111: op2 shifted by op1[SHAMT_W-1:0].
REQ-008 SHALL use sign-fill from op2 MSB for SRA/SRAV and zero-fill for other shifts.
REQ-009 SHALL compute SLT by a true signed comparison, correct for all operand pairs including overflow cases.
REQ-010 SHALL return result 0 with normal latency for any unlisted funct.
REQ-011 SHALL complete non-shift ops and shifts by 0 without entering SHIFT: DONE on the next edge, latency 1.
REQ-012 SHALL run shifts with amount N>0 as follows:
- Accepting edge loads the working register and applies the first step of min(SHIFT_STEP, N).
- Each later edge applies min(SHIFT_STEP, remaining).
- done rises after edge k = ceil(N/SHIFT_STEP); latency k cycles.
REQ-013 SHALL drive busy high exactly while in SHIFT.
REQ-014 SHALL drive done high only in DONE, for exactly one cycle per completed op.
REQ-015 SHALL update result only on the edge entering DONE, and hold it until the next completion.
REQ-016 SHALL ignore start while busy, with no effect on state or on the in-flight op.
REQ-017 SHALL accept a start in the DONE cycle (back-to-back): throughput 1 op/cycle for latency-1 ops.
REQ-018 SHALL, on flush, return to IDLE on the next edge with no done and result unchanged; flush beats start in the same cycle.
REQ-019 SHALL return from DONE to IDLE on the next edge when no start is accepted.

Reset
REQ-020 SHALL, with rst high at an edge, set state IDLE, busy 0, done 0, result 0, remaining count 0; rst dominates flush and start.
REQ-021 SHALL discard an op cut by reset mid-SHIFT, with no done produced afterwards.

Configuration
REQ-022 SHALL support macro LOGIC_ROTATE_EN; when defined:
- funct 000001 = ROTR, op2 rotated right by shamt.
- funct 000101 = ROTRV, op2 rotated right by op1[SHAMT_W-1:0].
- Both use the iterative timing of REQ-012.
REQ-023 SHALL, without LOGIC_ROTATE_EN, treat 000001 and 000101 as unlisted (REQ-010), with no rotate logic synthesised.

Verification (DATA_WIDTH=32, SHIFT_STEP=4)
REQ-024 SHALL cover AND, op1=0xF0F01234, op2=0x0FF0FFFF -> result 0x00F01234, done 1 cycle after start, busy never high.
REQ-025 SHALL cover SRAV, op1=0x00000009, op2=0x80000000 -> busy high for 2 cycles, done in cycle 3, result 0xFFC00000.
REQ-026 SHALL cover SLT and SLTU with op1=0x80000000, op2=0x7FFFFFFF -> SLT result 1, SLTU result 0.
REQ-027 SHALL cover:
- SLL shamt=31, flush in cycle 2 -> busy low next cycle, no done, result keeps previous value.
- Same op, rst in cycle 3 -> all outputs 0.
REQ-028 SHALL cover SRL shamt=8 started, a second start in cycle 1 (ignored), a third start (XOR) in the DONE cycle -> two done strobes, results 0x00123456 (op2=0x12345678) then XOR value one cycle later.
REQ-029 SHALL cover ROTR shamt=8, op2=0x12345678 -> 0x78123456 with LOGIC_ROTATE_EN, 0x00000000 without it.

Source files
------------

// File: rtl/ex_logic_shift_unit.sv
// Logic, compare and iterative shift unit for the EX stage.
// Define LOGIC_ROTATE_EN to add ROTR/ROTRV.
module ex_logic_shift_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 4,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [5:0]            funct,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA, K_ROR} kind_t;

  localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(SHIFT_STEP);

  state_t                  state_q, state_d;
  kind_t                   kind_q, kind_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0]      rem_q, rem_d;

  function automatic logic [DATA_WIDTH-1:0] step_fn(
    input logic [DATA_WIDTH-1:0] v,
    input kind_t                 k,
    input logic [SHAMT_W:0]      s
  );
    logic [DATA_WIDTH-1:0] r;
    case (k)
      K_SLL:   r = v << s;
      K_SRL:   r = v >> s;
      K_SRA:   r = DATA_WIDTH'($signed(v) >>> s);
`ifdef LOGIC_ROTATE_EN
      K_ROR:   r = (v >> s) | (v << (DATA_WIDTH - int'(s)));
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [SHAMT_W:0] min_step(input logic [SHAMT_W-1:0] n);
    logic [SHAMT_W:0] w;
    w = {1'b0, n};
    return (w > STEP_L) ? STEP_L : w;
  endfunction

  logic                  is_shift;
  kind_t                 dec_kind;
  logic [SHAMT_W-1:0]    dec_amt;
  logic [DATA_WIDTH-1:0] dec_res;
  logic [SHAMT_W:0]      s_amt;
  logic [DATA_WIDTH-1:0] s_val;
  logic                  accept;

  always_comb begin
    is_shift = 1'b0;
    dec_kind = K_SLL;
    dec_amt  = shamt;
    dec_res  = '0;
    case (funct)
      6'b100100: dec_res = operand_1 & operand_2;
      6'b100101,
      6'b001001: dec_res = operand_1 | operand_2;
      6'b100110: dec_res = operand_1 ^ operand_2;
      6'b100111: dec_res = ~(operand_1 | operand_2);
      6'b101010: dec_res = {{(DATA_WIDTH-1){1'b0}},
                            $signed(operand_1) < $signed(operand_2)};
      6'b101011: dec_res = {{(DATA_WIDTH-1){1'b0}}, operand_1 < operand_2};
      6'b000000: begin is_shift = 1'b1; dec_kind = K_SLL; end
      6'b000010: begin is_shift = 1'b1; dec_kind = K_SRL; end
      6'b000011: begin is_shift = 1'b1; dec_kind = K_SRA; end
      6'b000100: begin
        is_shift = 1'b1; dec_kind = K_SLL; dec_amt = operand_1[SHAMT_W-1:0];
      end
      6'b000110: begin
        is_shift = 1'b1; dec_kind = K_SRL; dec_amt = operand_1[SHAMT_W-1:0];
      end
      6'b000111: begin
        is_shift = 1'b1; dec_kind = K_SRA; dec_amt = operand_1[SHAMT_W-1:0];
      end
`ifdef LOGIC_ROTATE_EN
      6'b000001: begin is_shift = 1'b1; dec_kind = K_ROR; end
      6'b000101: begin
        is_shift = 1'b1; dec_kind = K_ROR; dec_amt = operand_1[SHAMT_W-1:0];
      end
`endif
      default: dec_res = '0;
    endcase
  end

  assign accept = start && !flush && (state_q != SHIFT);

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    s_amt    = '0;
    s_val    = '0;
    if (state_q == SHIFT) begin
      if (flush) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        s_amt  = min_step(rem_q);
        s_val  = step_fn(work_q, kind_q, s_amt);
        work_d = s_val;
        rem_d  = rem_q - s_amt[SHAMT_W-1:0];
        if (rem_d == '0) begin
          state_d  = DONE;
          result_d = s_val;
        end
      end
    end else begin
      state_d = IDLE;
      if (accept) begin
        if (is_shift && dec_amt != '0) begin
          // First step happens on the accepting edge itself.
          s_amt  = min_step(dec_amt);
          s_val  = step_fn(operand_2, dec_kind, s_amt);
          kind_d = dec_kind;
          work_d = s_val;
          rem_d  = dec_amt - s_amt[SHAMT_W-1:0];
          if (rem_d == '0) begin
            state_d  = DONE;
            result_d = s_val;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d  = DONE;
          rem_d    = '0;
          result_d = is_shift ? operand_2 : dec_res;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kind_q   <= K_SLL;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
